// File: rtl/riscv_load_store_unit.sv
// riscv_load_store_unit: RISC-V sub-word load/store adapter over a word-only data port.
// Ports: req_* handshake in, resp_* pulse out, mem_* word-aligned synchronous memory side.
module riscv_load_store_unit #(
  parameter logic [31:0] DATA_START_ADDRESS = 32'h00800000,
  parameter int          DATA_ADDR_BITS     = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_DATA = 2'd1;
  localparam logic [1:0] RMW_MERGE = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        accept;
  logic        in_range;
  logic        size_err;
  logic        req_err;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        need_rd;
  logic        is_sw;

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  off,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    r = w;
    unique case (sz)
      SZ_B: r = uns ? {24'b0, b}
                    : {{24{b[7]}}, b};
      SZ_H: r = uns ? {16'b0, h}
                    : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with store data.
  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [15:0] d,
    input logic [1:0]  sz,
    input logic [1:0]  off
  );
    logic [31:0] m;
    logic [31:0] ds;
    if (sz == SZ_H) begin
      m  = off[1] ? 32'hFFFF0000 : 32'h0000FFFF;
      ds = {2{d}};
    end else begin
      m  = 32'h000000FF << {off, 3'b000};
      ds = {4{d[7:0]}};
    end
    return (w & ~m) | (ds & m);
  endfunction

  assign is_b = (req_size == SZ_B);
  assign is_h = (req_size == SZ_H);
  assign is_w = (req_size == SZ_W);

  assign in_range =
    req_addr[31:DATA_ADDR_BITS] ==
    DATA_START_ADDRESS[31:DATA_ADDR_BITS];

  always_comb begin
    size_err = 1'b1;
    unique case (1'b1)
      is_b:    size_err = 1'b0;
      is_h:    size_err = req_addr[0];
      is_w:    size_err = |req_addr[1:0];
      default: size_err = 1'b1;
    endcase
  end

  assign req_err   = size_err | ~in_range;
  assign req_ready = rst & (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign is_sw     = req_write & is_w;
  // Loads and sub-word stores both start with a read.
  assign need_rd   = ~req_err & ~is_sw;

  always_comb begin
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = 32'h0;
    unique case (state)
      IDLE: begin
        mem_addr = {req_addr[31:2], 2'b00};
        if (req_valid && !req_err) begin
          if (is_sw) begin
            mem_write = 1'b1;
            mem_wdata = req_wdata;
          end else begin
            mem_read = 1'b1;
          end
        end
      end
      RMW_MERGE: begin
        mem_write = 1'b1;
        mem_wdata = merge(mem_rdata, wdata_q,
                          size_q, addr_q[1:0]);
      end
      default: ;
    endcase
    // Reset kills strobes in the same cycle.
    if (!rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_wdata = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 16'h0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata[15:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (is_sw) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_rdata <= 32'h0;
            end else if (need_rd && req_write) begin
              state <= RMW_MERGE;
            end else begin
              state <= LOAD_DATA;
            end
          end
        end
        LOAD_DATA: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= load_ext(mem_rdata, size_q,
                                 addr_q[1:0], uns_q);
        end
        RMW_MERGE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= 32'h0;
        end
        RESP: begin
          state      <= IDLE;
          resp_error <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/riscv_load_store_unit.md
Name: riscv_load_store_unit

Overview:
- Sits between the processor's memory stage and the word-only data memory port (dAddress/MemRead/MemWrite/dWriteData/dReadData).
- Adds RISC-V sub-word accesses: LB/LH/LW/LBU/LHU loads via byte/half extraction with sign or zero extension.
- SB/SH stores are done as read-modify-write.
- Provides a valid/ready request interface, a one-cycle response pulse, and misalignment error reporting.

Parameters:
- DATA_START_ADDRESS, 32'h00800000, base of data space; carried for address-range check.
- DATA_ADDR_BITS, 13, number of low address bits that index data memory; addresses outside the data space produce an error response.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  request present; held stable by requester until accepted
- req_ready  output  1  unit can accept; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  zero-extend loads (LBU/LHU); ignored for stores and words
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low byte/half used for SB/SH
- resp_valid  output  1  one-cycle completion pulse
- resp_error  output  1  qualifies resp_valid; misaligned, illegal size or out-of-range
- resp_rdata  output  32  extended load data; 0 for stores and errors
- mem_addr  output  32  word-aligned address to memory ({addr[31:2],2'b00})
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  synchronous memory read data, valid the cycle after address is presented

Behaviour:
- States: IDLE, LOAD_DATA, RMW_MERGE, RESP.
- Reset (rst=0, async): state=IDLE, all registered outputs 0 (resp_valid, resp_error, resp_rdata), request registers 0. mem_read, mem_write and mem_wdata are 0. req_ready=1 once reset deasserts.
- Accept: req_valid && req_ready on a rising edge; in IDLE, the mem_* outputs are driven combinationally from req_*.
- Error check at accept: error if any of the following:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:DATA_ADDR_BITS]!=DATA_START_ADDRESS[31:DATA_ADDR_BITS]
- Error response: no mem_read or mem_write is issued; next state RESP with resp_error=1, resp_rdata=0.
- LW/LH/LB (T = accept cycle): mem_read=1 at T → LOAD_DATA at T+1.
  - In LOAD_DATA, select the byte by addr[1:0] (lane 0 = bits 7:0, little-endian) or the half by addr[1].
  - Sign- or zero-extend, register into resp_rdata → RESP at T+2.
  - Load latency is 2 cycles, accept to resp_valid.
- SW: mem_write=1, mem_wdata=req_wdata at T → RESP at T+1.
- SB/SH, read phase: mem_read=1 at T → RMW_MERGE at T+1.
- SB/SH, merge phase (RMW_MERGE):
  - mem_addr = registered aligned address.
  - mem_wdata = mem_rdata with the target byte/half replaced by the registered store data.
  - mem_write=1 for exactly one cycle → RESP at T+2.
- RESP: resp_valid=1 for one cycle, req_ready=0 → IDLE. Back-to-back: next accept at earliest the cycle after RESP.
- mem_write and mem_read are never asserted in RESP or while rst=0. At most one mem_write per request.
- req_valid while req_ready=0 is ignored; the request is not latched.
- Reset mid-operation (any state): abort immediately. No write is issued, and no resp_valid for the aborted request.
- Request fields are registered at accept; changes to req_* after accept have no effect.

Test Plan:
- Memory word 0x00800004 = 0x80FF7F01; LB addr 0x00800006 → resp_rdata 0xFFFFFFFF; LBU → 0x000000FF; LB addr 0x00800005 → 0x0000007F. resp_valid exactly 2 cycles after accept.
- Same word; LH addr 0x00800006 → 0xFFFF80FF; LHU → 0x000080FF; LW 0x00800004 → 0x80FF7F01.
- Word 0x00800008 = 0x11223344; SB wdata 0xAB to 0x00800009 → single mem_write with 0x1122AB44 at T+1. Following SH wdata 0xBEEF to 0x0080000A → memory 0xBEEFAB44.
- SW 0xDEADBEEF to 0x0080000C → mem_write at T, resp_valid at T+1, mem_read never asserted.
- Error responses, with no mem_read/mem_write in any case:
  - LW 0x00800002 → resp_valid with resp_error=1.
  - SH 0x00800001 → resp_error=1.
  - size=11 → resp_error=1.
  - LW 0x00400000 → resp_error=1.
- Start SB, assert rst low during RMW_MERGE → mem_write drops to 0 that cycle; after release: IDLE, req_ready=1, no resp_valid, memory word unchanged.
